// File: rtl/gf256_pkg.sv
// GF(256) arithmetic helpers and constants shared by the RS(204,188) decoder stages.
// The field polynomial is x^8+x^4+x^3+x^2+1; GF_POLY holds its low byte.
package gf256_pkg;

  localparam logic [7:0] GF_POLY = 8'h1D;
  localparam int         N_POS   = 204;
  localparam int         T       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } chien_state_e;

  function automatic logic [7:0] gf_mul_alpha(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  // a * alpha^k; with a constant k this folds into a fixed XOR network
  function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input int k);
    logic [7:0] acc;
    acc = a;
    for (int i = 0; i < (k % 255); i++) begin
      acc = gf_mul_alpha(acc);
    end
    return acc;
  endfunction

endpackage

// File: rtl/chien_search_const_mul.sv
// Multiplies a GF(256) element by the fixed power alpha^K.
module gf_const_mul
  import gf256_pkg::*;
#(
  parameter int K = 1
) (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = gf_mul_const(a_i, K);

endmodule

// File: rtl/chien_search.sv
// Chien search for RS(204,188): evaluates the error locator at alpha^-p for p = 0..203
// and reports each root as X = alpha^p, in ascending p order.
module chien_search
  import gf256_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       start,
  input  logic [7:0] lambda0,
  input  logic [7:0] lambda1,
  input  logic [7:0] lambda2,
  input  logic [7:0] lambda3,
  input  logic [7:0] lambda4,
  input  logic [7:0] lambda5,
  input  logic [7:0] lambda6,
  input  logic [7:0] lambda7,
  input  logic [7:0] lambda8,
  output logic [7:0] el1,
  output logic [7:0] el2,
  output logic [7:0] el3,
  output logic [7:0] el4,
  output logic [7:0] el5,
  output logic [7:0] el6,
  output logic [7:0] el7,
  output logic [7:0] el8,
  output logic [3:0] err_cnt,
  output logic       done,
  output logic       busy,
  output logic       fail
);

  chien_state_e state_q, state_d;
  logic [7:0] lam_s   [0:T];
  logic [7:0] r_q     [0:T];
  logic [7:0] r_d     [0:T];
  logic [7:0] r_mul_s [0:T];
  logic [7:0] el_q    [0:T-1];
  logic [7:0] el_d    [0:T-1];
  logic [7:0] x_q, x_d, x_mul_s;
  logic [7:0] p_q, p_d;
  logic [3:0] cnt_q, cnt_d, deg_q, deg_d, deg_s;
  logic       ovf_q, ovf_d;
  logic       done_q, done_d, busy_q, busy_d, fail_q, fail_d;
  logic [7:0] s_s;
  logic       last_s;

  assign lam_s[0] = lambda0;
  assign lam_s[1] = lambda1;
  assign lam_s[2] = lambda2;
  assign lam_s[3] = lambda3;
  assign lam_s[4] = lambda4;
  assign lam_s[5] = lambda5;
  assign lam_s[6] = lambda6;
  assign lam_s[7] = lambda7;
  assign lam_s[8] = lambda8;

  // r_k steps by alpha^-k each position, so r_k = lambda_k * alpha^(-k*p)
  for (genvar k = 0; k <= T; k++) begin : g_rmul
    gf_const_mul #(.K((255 - k) % 255)) u_rmul (.a_i(r_q[k]), .y_o(r_mul_s[k]));
  end

  gf_const_mul #(.K(1)) u_xmul (.a_i(x_q), .y_o(x_mul_s));

  always_comb begin
    s_s = 8'h00;
    for (int k = 0; k <= T; k++) begin
      s_s = s_s ^ r_q[k];
    end
  end

  always_comb begin
    deg_s = 4'd0;
    for (int k = 1; k <= T; k++) begin
      deg_s = (lam_s[k] != 8'h00) ? 4'(k) : deg_s;
    end
  end

  assign last_s = (p_q == 8'(N_POS - 1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = start ? ST_SCAN : ST_IDLE;
      ST_SCAN: state_d = last_s ? ST_DONE : ST_SCAN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    r_d    = r_q;
    el_d   = el_q;
    x_d    = x_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    deg_d  = deg_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    busy_d = busy_q;
    fail_d = fail_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          r_d    = lam_s;
          x_d    = 8'h01;
          p_d    = 8'h00;
          cnt_d  = 4'd0;
          ovf_d  = 1'b0;
          deg_d  = deg_s;
          busy_d = 1'b1;
          fail_d = 1'b0;
          for (int i = 0; i < T; i++) begin
            el_d[i] = 8'h00;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_SCAN: begin
        r_d = r_mul_s;
        x_d = x_mul_s;
        p_d = p_q + 8'd1;
        if (s_s == 8'h00) begin
          if (cnt_q < 4'(T)) begin
            el_d[cnt_q[2:0]] = x_q;
            cnt_d            = cnt_q + 4'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          ovf_d = ovf_q;
        end
        // the verdict must include a root found at the final position
        if (last_s) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          fail_d = ovf_d | (cnt_d != deg_q) | (r_q[0] == 8'h00);
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_DONE: busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int k = 0; k <= T; k++) begin
        r_q[k] <= 8'h00;
      end
      for (int i = 0; i < T; i++) begin
        el_q[i] <= 8'h00;
      end
      x_q    <= 8'h00;
      p_q    <= 8'h00;
      cnt_q  <= 4'd0;
      deg_q  <= 4'd0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      el_q   <= el_d;
      x_q    <= x_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      deg_q  <= deg_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
      busy_q <= busy_d;
      fail_q <= fail_d;
    end
  end

  assign el1     = el_q[0];
  assign el2     = el_q[1];
  assign el3     = el_q[2];
  assign el4     = el_q[3];
  assign el5     = el_q[4];
  assign el6     = el_q[5];
  assign el7     = el_q[6];
  assign el8     = el_q[7];
  assign err_cnt = cnt_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign fail    = fail_q;

endmodule

// File: tb/tb_chien_search.sv
// Scoreboard bench for chien_search: a Horner-evaluation reference model predicts each
// accepted request, and a monitor compares the results whenever done pulses.
module tb_chien_search;

  typedef struct packed {
    logic [7:0][7:0] el;
    logic [3:0]      cnt;
    logic            fail;
    int              t0;
  } exp_t;

  logic            Clk;
  logic            Rst;
  logic            start;
  logic [8:0][7:0] lam_r;
  logic [7:0]      el1, el2, el3, el4, el5, el6, el7, el8;
  logic [3:0]      err_cnt;
  logic            done, busy, fail;
  logic [7:0][7:0] el_v;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic done_prev = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;

  chien_search dut (
    .Clk(Clk), .Rst(Rst), .start(start),
    .lambda0(lam_r[0]), .lambda1(lam_r[1]), .lambda2(lam_r[2]),
    .lambda3(lam_r[3]), .lambda4(lam_r[4]), .lambda5(lam_r[5]),
    .lambda6(lam_r[6]), .lambda7(lam_r[7]), .lambda8(lam_r[8]),
    .el1(el1), .el2(el2), .el3(el3), .el4(el4),
    .el5(el5), .el6(el6), .el7(el7), .el8(el8),
    .err_cnt(err_cnt), .done(done), .busy(busy), .fail(fail)
  );

  assign el_v = {el8, el7, el6, el5, el4, el3, el2, el1};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Carry-less product followed by reduction modulo 0x11D
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) prod = prod ^ (16'(a) << i);
    end
    for (int i = 14; i >= 8; i--) begin
      if (prod[i]) prod = prod ^ (16'h011D << (i - 8));
    end
    return prod[7:0];
  endfunction

  function automatic logic [7:0] gpow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < (e % 255); i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic exp_t model(input logic [8:0][7:0] lam, input int t0);
    exp_t       e;
    int         nroots;
    int         deg;
    int         kept;
    logic [7:0] xinv;
    logic [7:0] acc;
    e.el   = '0;
    e.t0   = t0;
    nroots = 0;
    deg    = 0;
    for (int k = 1; k <= 8; k++) begin
      if (lam[k] != 8'h00) deg = k;
    end
    for (int p = 0; p < 204; p++) begin
      xinv = gpow((255 - p) % 255);
      acc  = 8'h00;
      for (int k = 8; k >= 0; k--) acc = gmul(acc, xinv) ^ lam[k];
      if (acc == 8'h00) begin
        if (nroots < 8) e.el[nroots] = gpow(p);
        nroots++;
      end
    end
    kept   = (nroots > 8) ? 8 : nroots;
    e.cnt  = 4'(kept);
    e.fail = (nroots > 8) || (kept != deg) || (lam[0] == 8'h00);
    return e;
  endfunction

  // c * prod(1 + alpha^p x): one root at alpha^-p for each listed p
  function automatic logic [8:0][7:0] poly_from_roots(input int rts[8], input int n,
                                                      input logic [7:0] c);
    logic [8:0][7:0] l;
    logic [7:0]      xi;
    l    = '0;
    l[0] = c;
    for (int i = 0; i < n; i++) begin
      xi = gpow(rts[i]);
      for (int k = 8; k >= 1; k--) l[k] = l[k] ^ gmul(xi, l[k-1]);
    end
    return l;
  endfunction

  always @(negedge Clk) begin
    if (!Rst && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        for (int i = 0; i < 8; i++) begin
          chk($sformatf("el%0d", i + 1), int'(el_v[i]), int'(mon_e.el[i]));
        end
        chk("err_cnt", int'(err_cnt), int'(mon_e.cnt));
        chk("fail", int'(fail), int'(mon_e.fail));
        // start cycle is cycle 0, done occupies cycle 205: 204 edges after sampling
        chk("latency", cyc - mon_e.t0, 204);
        chk("busy_at_done", int'(busy), 0);
        chk("done_width", int'(done_prev), 0);
      end
    end
    done_prev = done;
  end

  task automatic issue(input logic [8:0][7:0] lam, input bit track);
    @(negedge Clk);
    lam_r = lam;
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    if (track) sb_q.push_back(model(lam, cyc));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(negedge Clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("done_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_el%0d", tag, i + 1), int'(el_v[i]), 0);
    end
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_fail"}, int'(fail), 0);
  endtask

  initial begin
    logic [8:0][7:0] lam;
    int              rts[8];
    int              n;

    Rst   = 1'b1;
    start = 1'b0;
    lam_r = '0;
    repeat (3) @(negedge Clk);
    chk_all_zero("reset");
    Rst = 1'b0;

    lam = '0; lam[0] = 8'd1; lam[1] = 8'd2;                    // root at p=1
    issue(lam, 1'b1); wait_idle();
    lam = '0; lam[0] = 8'd1; lam[1] = 8'd3; lam[2] = 8'd2;     // roots at p=0,1
    issue(lam, 1'b1); wait_idle();
    lam = '0; lam[0] = 8'd1;                                   // no errors
    issue(lam, 1'b1); wait_idle();
    lam = '0; lam[0] = 8'd1; lam[1] = 8'd142;                  // root at p=254
    issue(lam, 1'b1); wait_idle();
    lam = '0;                                                  // every position is a root
    issue(lam, 1'b1); wait_idle();
    lam = '0; lam[1] = 8'd5;                                   // lambda0 == 0
    issue(lam, 1'b1); wait_idle();
    rts = '{0, 25, 50, 75, 100, 125, 150, 203};
    issue(poly_from_roots(rts, 8, 8'd1), 1'b1); wait_idle();
    rts = '{203, 204, 0, 0, 0, 0, 0, 0};
    issue(poly_from_roots(rts, 2, 8'd7), 1'b1); wait_idle();

    // second start mid-scan must be ignored
    lam = '0; lam[0] = 8'd1; lam[1] = 8'd2;
    issue(lam, 1'b1);
    repeat (49) @(negedge Clk);
    lam = '0; lam[0] = 8'd1; lam[1] = 8'd3; lam[2] = 8'd2;
    issue(lam, 1'b0);
    wait_idle();
    repeat (3) @(negedge Clk);
    chk("no_restart_busy", int'(busy), 0);

    // reset in the middle of a scan
    lam = '0; lam[0] = 8'd1; lam[1] = 8'd3; lam[2] = 8'd2;
    issue(lam, 1'b1);
    repeat (99) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk_all_zero("midscan_rst");
    Rst = 1'b0;
    sb_q.delete();
    issue(lam, 1'b1); wait_idle();

    // start coincident with reset is dropped
    @(negedge Clk);
    Rst   = 1'b1;
    start = 1'b1;
    @(negedge Clk);
    Rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_beats_start_busy", int'(busy), 0);

    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k <= 8; k++) lam[k] = 8'($urandom_range(0, 255));
      end else begin
        n = $urandom_range(0, 8);
        for (int i = 0; i < 8; i++) rts[i] = $urandom_range(0, 254);
        lam = poly_from_roots(rts, n, 8'($urandom_range(1, 255)));
      end
      repeat ($urandom_range(0, 5)) @(negedge Clk);
      issue(lam, 1'b1);
      wait_idle();
    end

    repeat (5) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
